// File: rtl/baggage_tag_tx.sv
// ---------------------------------------------------------------------------
// baggage_tag_tx
// Serial transmitter for baggage data frames. Accepts one DATA_W-bit word per
// valid/ready handshake, appends a parity bit and shifts the frame out on a
// single line that idles high.
//
// Frame on tx_serial: start(0), DATA_W data bits LSB first, parity, stop(1).
// Each bit is held CLKS_PER_BIT cycles.
//
// Handshake: a word is accepted on a rising edge where tx_valid && tx_ready
// are both high. tx_ready is high only in IDLE; tx_valid while tx_ready is
// low is ignored (nothing is queued), and tx_data is only sampled on accept.
//
// Ports:
//   clk          in   1       rising-edge clock
//   reset        in   1       synchronous, active-high; wins over everything
//   tx_valid     in   1       upstream offers a word on tx_data
//   tx_data      in   DATA_W  baggage word
//   tx_ready     out  1       block can accept a word this cycle
//   tx_serial    out  1       serial line, idles high
//   busy         out  1       frame in progress
//   frame_done   out  1       one-cycle pulse on the final stop-bit cycle
//   frame_count  out  4       completed frames, modulo 16
//   dbg_state    out  3       current FSM state (for checkers/debug)
// ---------------------------------------------------------------------------
module baggage_tag_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              busy,
    output logic              frame_done,
    output logic [3:0]        frame_count,
    output logic [2:0]        dbg_state
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DATA_W - 1);
    localparam logic          ODD_BIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              tx_ready_q, tx_ready_d;
    logic              tx_serial_q, tx_serial_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic [3:0]        frame_count_q, frame_count_d;

    logic              bit_end;

    // Next-state logic. Outputs are derived from the *next* state so that the
    // registered outputs line up with the state they describe (e.g. the line
    // drops to 0 on the first cycle after accept).
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        data_d  = data_q;
        bit_end = (timer_q == TIMER_MAX);

        // Bit timer free-runs 0..CLKS_PER_BIT-1 while a frame is in flight.
        if (state_q != S_IDLE) begin
            timer_d = bit_end ? '0 : timer_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    data_d  = tx_data;
                    state_d = S_START;
                    timer_d = '0;
                    idx_d   = '0;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_MAX) state_d = S_PARITY;
                    else                  idx_d   = idx_q + IW'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        tx_ready_d    = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
        // Final stop-bit cycle: the counter steps in the same cycle as the pulse.
        frame_done_d  = (state_d == S_STOP) && (timer_d == TIMER_MAX);
        frame_count_d = frame_count_q + {3'b000, frame_done_d};

        case (state_d)
            S_START:  tx_serial_d = 1'b0;
            S_DATA:   tx_serial_d = data_d[idx_d];
            S_PARITY: tx_serial_d = (^data_d) ^ ODD_BIT;
            default:  tx_serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            idx_q         <= '0;
            data_q        <= '0;
            tx_ready_q    <= 1'b1;
            tx_serial_q   <= 1'b1;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 4'd0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            idx_q         <= idx_d;
            data_q        <= data_d;
            tx_ready_q    <= tx_ready_d;
            tx_serial_q   <= tx_serial_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign tx_ready    = tx_ready_q;
    assign tx_serial   = tx_serial_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_baggage_tag_tx.sv
// ---------------------------------------------------------------------------
// tb_baggage_tag_tx
// Two transmitters share clock and reset:
//   instance 0: defaults (8 data bits, 4 clks/bit, even parity)
//   instance 1: 8 data bits, 1 clk/bit, odd parity
// Expected line values come from the frame definition: bit position
// (cycle-1)/clks_per_bit selects start / data[LSB first] / parity / stop.
// ---------------------------------------------------------------------------
module tb_baggage_tag_tx;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals (index = instance) ----------------
    logic       valid [2];
    logic [7:0] data  [2];
    logic       ready [2];
    logic       serial[2];
    logic       busy  [2];
    logic       done  [2];
    logic [3:0] cnt   [2];
    logic [2:0] dbg   [2];

    baggage_tag_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .tx_valid(valid[0]), .tx_data(data[0]), .tx_ready(ready[0]),
        .tx_serial(serial[0]), .busy(busy[0]), .frame_done(done[0]),
        .frame_count(cnt[0]), .dbg_state(dbg[0])
    );

    baggage_tag_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_ODD(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .tx_valid(valid[1]), .tx_data(data[1]), .tx_ready(ready[1]),
        .tx_serial(serial[1]), .busy(busy[1]), .frame_done(done[1]),
        .frame_count(cnt[1]), .dbg_state(dbg[1])
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int model_cnt[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Line value at frame bit position pos (0 = start, 10 = stop).
    function automatic logic exp_line(input logic [7:0] d, input int pos, input int odd);
        if (pos == 0)      return 1'b0;
        else if (pos <= 8) return d[pos-1];
        else if (pos == 9) return logic'((($countones(d) + odd) % 2) != 0);
        else               return 1'b1;
    endfunction

    task automatic check_idle(input int sel, input string tag);
        check($sformatf("%s_i%0d_serial", tag, sel), 32'(serial[sel]), 32'd1);
        check($sformatf("%s_i%0d_ready",  tag, sel), 32'(ready[sel]),  32'd1);
        check($sformatf("%s_i%0d_busy",   tag, sel), 32'(busy[sel]),   32'd0);
        check($sformatf("%s_i%0d_done",   tag, sel), 32'(done[sel]),   32'd0);
        check($sformatf("%s_i%0d_count",  tag, sel), 32'(cnt[sel]),    32'(model_cnt[sel]));
    endtask

    // ---------------- driver + per-cycle frame check ----------------
    // Called at a negedge with the instance idle. Offers word d, then follows
    // the whole frame. hold keeps tx_valid high with next_d during the frame;
    // noise toggles tx_valid/tx_data randomly during the frame. Returns at the
    // negedge of the first cycle after the frame (expected idle-high).
    task automatic run_frame(input int sel, input logic [7:0] d, input bit hold,
                             input logic [7:0] next_d, input bit noise);
        int cpb;
        int len;
        cpb = (sel == 0) ? 4 : 1;
        len = 11 * cpb;
        check($sformatf("pre_i%0d_ready", sel), 32'(ready[sel]), 32'd1);
        valid[sel] = 1'b1;
        data[sel]  = d;
        @(posedge clk);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (hold) begin
                valid[sel] = 1'b1;
                data[sel]  = next_d;
            end else if (noise) begin
                valid[sel] = 1'($urandom_range(0, 1));
                data[sel]  = 8'($urandom);
            end else begin
                valid[sel] = 1'b0;
            end
            if (c == len) model_cnt[sel] = (model_cnt[sel] + 1) % 16;
            check($sformatf("i%0d_d%02h_line_c%0d", sel, d, c), 32'(serial[sel]),
                  32'(exp_line(d, (c - 1) / cpb, sel)));
            check($sformatf("i%0d_ready_c%0d", sel, c), 32'(ready[sel]), 32'd0);
            check($sformatf("i%0d_busy_c%0d",  sel, c), 32'(busy[sel]),  32'd1);
            check($sformatf("i%0d_done_c%0d",  sel, c), 32'(done[sel]),  32'(c == len));
            check($sformatf("i%0d_count_c%0d", sel, c), 32'(cnt[sel]),   32'(model_cnt[sel]));
        end
        @(negedge clk);
        if (!hold) valid[sel] = 1'b0;
        check_idle(sel, "post");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            valid[i]     = 1'b0;
            data[i]      = 8'h00;
            model_cnt[i] = 0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle(0, "rst");
        check_idle(1, "rst");
        reset = 1'b0;
        @(negedge clk);

        // Known words: 0xA5 on defaults, 0x07 with even and odd parity.
        run_frame(0, 8'hA5, 1'b0, 8'h00, 1'b0);
        run_frame(0, 8'h07, 1'b0, 8'h00, 1'b0);
        run_frame(1, 8'h07, 1'b0, 8'h00, 1'b0);
        run_frame(1, 8'hA5, 1'b0, 8'h00, 1'b0);

        // tx_valid held high: second accept exactly one idle cycle later.
        run_frame(0, 8'h3C, 1'b1, 8'hC3, 1'b0);
        run_frame(0, 8'hC3, 1'b0, 8'h00, 1'b0);

        // Random data/valid activity during frames must be ignored.
        for (int i = 0; i < 3; i++) run_frame(0, 8'($urandom), 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) run_frame(1, 8'($urandom), 1'b0, 8'h00, 1'b1);

        // Reset during data bit 3 (frame cycles 17..20 on instance 0).
        valid[0] = 1'b1;
        data[0]  = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (16) @(negedge clk);
        check("pre_reset_busy", 32'(busy[0]), 32'd1);
        reset = 1'b1;
        model_cnt[0] = 0;
        model_cnt[1] = 0;
        @(negedge clk);
        reset = 1'b0;
        check_idle(0, "midrst");
        check_idle(1, "midrst");
        @(negedge clk);
        check_idle(0, "midrst2");

        // 17 frames: counter walks 15 -> 0 -> 1.
        for (int i = 0; i < 17; i++) run_frame(0, 8'($urandom), 1'b0, 8'h00, 1'b0);
        check("wrap_count_i0", 32'(cnt[0]), 32'd1);
        for (int i = 0; i < 17; i++) run_frame(1, 8'($urandom), 1'b0, 8'h00, 1'b0);
        check("wrap_count_i1", 32'(cnt[1]), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
